button_matrix_scanner: RTL and testbench

Scans an N x N key/button matrix and reconstructs the pressed-key state as a debounced N*N bitmap. It is the input-side counterpart of the LED array driver.
- It drives one-hot active-high columns and reads active-low rows.
- Its bit mapping is identical to the driver's: key (row i, col j) maps to cells[i*N+j].
- Output feeds the Conway grid (cell editing) or any consumer of a cells bus.

---
 rtl/button_matrix_scanner.sv | 191 +++++++++++++++++++
 tb/tb_button_matrix_scanner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : button_matrix_scanner
// Purpose  : Scans an N x N key matrix by driving one column at a time
//            (one-hot, active-high) and reading active-low rows. Keys are
//            debounced per key across frames and presented as an N*N bitmap,
//            key (row i, col j) -> cells[i*N+j], 1 = pressed.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            ena             - scan enable (checked in IDLE and at sample exit)
//            rows[N]         - row sense, active-low, asynchronous to clk
//            cols[N]         - one-hot column drive, 0 when idle
//            x               - index of the driven column
//            cells[N*N]      - debounced key bitmap
//            frame_done      - 1-cycle pulse after column N-1 is sampled
//            changed         - 1-cycle pulse with frame_done if any bit flipped
// Revision : 1.0 - initial release
// ============================================================================
module button_matrix_scanner #(
  parameter  int N              = 8,
  parameter  int SETTLE_CYCLES  = 4,
  parameter  int DEBOUNCE_SCANS = 2,
  localparam int XW             = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [N-1:0]    rows,
  output logic [N-1:0]    cols,
  output logic [XW-1:0]   x,
  output logic [N*N-1:0]  cells,
  output logic            frame_done,
  output logic            changed
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST      = XW'(N - 1);
  localparam logic [DW-1:0] DB_LIMIT    = DW'(DEBOUNCE_SCANS);

  initial begin
    if (N < 1 || N > 8)
      $error("button_matrix_scanner: N must be in 1..8");
    if (SETTLE_CYCLES < 3)
      $error("button_matrix_scanner: SETTLE_CYCLES must be >= 3");
    if (DEBOUNCE_SCANS < 1)
      $error("button_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [XW-1:0]   x_d;
  logic [CW-1:0]   settle_cnt, settle_cnt_d;
  logic [N-1:0]    col_sel;
  logic            last_sample;

  logic [N-1:0]    rows_m, rows_s;
  logic [N-1:0]    sample;
  logic [N*N-1:0]  cells_d;
  logic [DW-1:0]   db_cnt [N*N];
  logic [DW-1:0]   db_cnt_d [N*N];
  logic [DW-1:0]   db_inc;
  logic            flip_any;
  logic            chg_flag;

  // One-hot decode of the current column index
  always_comb begin
    col_sel = '0;
    for (int j = 0; j < N; j++) begin
      col_sel[j] = (x == XW'(j));
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x          <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_d;
      x          <= x_d;
      settle_cnt <= settle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    x_d          = x;
    settle_cnt_d = settle_cnt;
    cols         = '0;
    last_sample  = 1'b0;
    case (state)
      S_IDLE: begin
        x_d          = '0;
        settle_cnt_d = '0;
        if (ena) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cols         = col_sel;
        settle_cnt_d = settle_cnt + CW'(1);
        if (settle_cnt == SETTLE_LAST) begin
          state_d      = S_SAMPLE;
          settle_cnt_d = '0;
        end
      end
      S_SAMPLE: begin
        cols         = col_sel;
        settle_cnt_d = '0;
        last_sample  = (x == X_LAST);
        // Dropping ena parks at column 0 so a re-enable always starts a frame
        if (ena) begin
          state_d = S_SETTLE;
          x_d     = last_sample ? '0 : x + XW'(1);
        end else begin
          state_d = S_IDLE;
          x_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        x_d     = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-key debounce for the column being sampled
  // --------------------------------------------------------------------------
  assign sample = ~rows_s;

  always_comb begin
    cells_d  = cells;
    db_cnt_d = db_cnt;
    flip_any = 1'b0;
    db_inc   = '0;
    if (state == S_SAMPLE) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (col_sel[j]) begin
            if (sample[i] == cells[i*N+j]) begin
              db_cnt_d[i*N+j] = '0;
            end else begin
              db_inc = db_cnt[i*N+j] + DW'(1);
              if (db_inc == DB_LIMIT) begin
                cells_d[i*N+j]  = ~cells[i*N+j];
                db_cnt_d[i*N+j] = '0;
                flip_any        = 1'b1;
              end else begin
                db_cnt_d[i*N+j] = db_inc;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_m     <= '1;
      rows_s     <= '1;
      cells      <= '0;
      frame_done <= 1'b0;
      changed    <= 1'b0;
      chg_flag   <= 1'b0;
      for (int k = 0; k < N*N; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      rows_m     <= rows;
      rows_s     <= rows_m;
      cells      <= cells_d;
      db_cnt     <= db_cnt_d;
      frame_done <= last_sample;
      // Flips from the final column's sample belong to the frame just ending
      changed    <= last_sample & (chg_flag | flip_any);
      chg_flag   <= last_sample ? 1'b0 : (chg_flag | flip_any);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_matrix_scanner
// Purpose  : Self-checking bench for button_matrix_scanner (N=8,
//            SETTLE_CYCLES=4, DEBOUNCE_SCANS=2). Expected per-frame results
//            are queued by the stimulus; a monitor pops them on frame_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_matrix_scanner;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [N-1:0]  rows;
  logic [N-1:0]  cols;
  logic [2:0]    x;
  logic [63:0]   cells;
  logic          frame_done;
  logic          changed;

  logic [63:0]   pressed;

  typedef struct {
    logic [63:0] cells;
    logic        chg;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] K21 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] K4  = 64'h8000_0000_0000_0080;

  button_matrix_scanner #(
    .N              (8),
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rows       (rows),
    .cols       (cols),
    .x          (x),
    .cells      (cells),
    .frame_done (frame_done),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven
  always_comb begin
    rows = '1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (cols[j] && pressed[i*N+j]) rows[i] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] c, input logic chg);
    exp_t e;
    e.cells = c;
    e.chg   = chg;
    q.push_back(e);
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL frame_timeout: actual=no frame_done required=frame_done within 200 cycles");
  endtask

  // Monitor: compares each frame_done against the oldest queued expectation
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done: actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        check("frame_cells", cells, mon_e.cells);
        check("frame_changed", 64'(changed), 64'(mon_e.chg));
      end
    end else if (changed === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL changed_without_frame_done: actual=1 required=0 (t=%0t)", $time);
    end
  end

  initial begin
    logic [7:0] exp_cols;
    pressed = '0;
    rst     = 1'b1;
    ena     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cells", cells, 64'd0);
    check("reset_cols", 64'(cols), 64'd0);
    check("reset_x", 64'(x), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_changed", 64'(changed), 64'd0);

    // 1. Idle scan, column sequence and timing
    rst = 1'b0;
    ena = 1'b1;
    push(64'd0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      exp_cols = 8'd1 << (c / 5);
      check("scan_cols", 64'(cols), 64'(exp_cols));
      check("scan_x", 64'(x), 64'(c / 5));
    end
    wait_frame();
    push(64'd0, 1'b0);
    wait_frame();

    // 2. Held key (2,5), then release
    pressed = K21;
    push(64'd0, 1'b0); wait_frame();
    push(K21, 1'b1);   wait_frame();
    push(K21, 1'b0);   wait_frame();
    pressed = '0;
    push(K21, 1'b0);   wait_frame();
    push(64'd0, 1'b1); wait_frame();

    // 3. One-frame bounce is rejected
    pressed = K21;
    push(64'd0, 1'b0); wait_frame();
    pressed = '0;
    push(64'd0, 1'b0); wait_frame();
    push(64'd0, 1'b0); wait_frame();

    // 4. Two keys in column 7
    pressed = K4;
    push(64'd0, 1'b0); wait_frame();
    push(K4, 1'b1);    wait_frame();
    push(K4, 1'b0);    wait_frame();

    // 5. Drop ena during column 3 settle
    repeat (16) @(negedge clk);
    check("col3_settle_cols", 64'(cols), 64'h08);
    check("col3_settle_x", 64'(x), 64'd3);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check("col3_sample_cols", 64'(cols), 64'h08);
    @(negedge clk);
    check("idle_cols", 64'(cols), 64'd0);
    check("idle_x", 64'(x), 64'd0);
    repeat (10) @(negedge clk);
    check("idle_hold_cols", 64'(cols), 64'd0);
    check("idle_cells", cells, K4);
    ena = 1'b1;
    push(K4, 1'b0);
    @(negedge clk);
    check("resume_cols", 64'(cols), 64'h01);
    check("resume_x", 64'(x), 64'd0);
    wait_frame();

    // 6. Reset mid-frame with cells nonzero
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cells", cells, 64'd0);
    check("midrst_cols", 64'(cols), 64'd0);
    check("midrst_x", 64'(x), 64'd0);
    check("midrst_frame_done", 64'(frame_done), 64'd0);
    pressed = '0;
    rst     = 1'b0;
    push(64'd0, 1'b0);
    @(negedge clk);
    check("restart_cols", 64'(cols), 64'h01);
    check("restart_x", 64'(x), 64'd0);
    wait_frame();

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
